// File: rtl/cordic_sequencer_if.sv
// cordic_sequencer_if: job request and result response handshakes of the cordic sequencer
interface cordic_sequencer_if #(parameter int W = 32);
  logic req_valid, req_ready, req_mode;
  logic signed [W-1:0] req_a, req_b;
  logic resp_valid, resp_ready, resp_err;
  logic signed [W-1:0] resp_x, resp_y, resp_z;
  modport master (
    output req_valid, req_mode, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_x, resp_y, resp_z, resp_err
  );
  modport slave (
    input  req_valid, req_mode, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_x, resp_y, resp_z, resp_err
  );
endinterface

// File: rtl/cordic_sequencer.sv
// cordic_sequencer: folds jobs into the cordic convergence range, runs the core once, unfolds results
module cordic_sequencer #(
  parameter int W = 32,
  parameter int PI_FIXED = 102944,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  cordic_sequencer_if.slave bus,
  output logic core_start,
  output logic core_mode,
  output logic signed [W-1:0] core_x,
  output logic signed [W-1:0] core_y,
  output logic signed [W-1:0] core_z,
  input  logic core_done,
  input  logic signed [W-1:0] core_x_out,
  input  logic signed [W-1:0] core_y_out,
  input  logic signed [W-1:0] core_z_out
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, FIX, RESP} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic signed [W-1:0] PI = W'(PI_FIXED);
  localparam logic signed [W-1:0] NPI = -PI;
  localparam logic signed [W-1:0] HPI = W'(PI_FIXED / 2);
  localparam logic signed [W-1:0] NHPI = -HPI;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic fold, yneg, rot_err, rot_fold, timeout;
  // sum arrives in W+1 bits; clamp when the two top bits disagree
  function automatic logic signed [W-1:0] sat(input logic [W:0] s);
    return s[W] ^ s[W-1] ? {s[W], {(W-1){~s[W]}}} : s[W-1:0];
  endfunction
  function automatic logic signed [W-1:0] add(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    return sat({a[W-1], a} + {b[W-1], b});
  endfunction
  function automatic logic signed [W-1:0] neg(input logic signed [W-1:0] a);
    return sat(-{a[W-1], a});
  endfunction
  assign rot_err = !bus.req_mode && (bus.req_a > PI || bus.req_a < NPI);
  assign rot_fold = bus.req_a > HPI || bus.req_a < NHPI;
  assign timeout = cnt == CW'(TIMEOUT - 1);
  assign bus.req_ready = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign core_start = state == LAUNCH;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.req_valid ? (rot_err ? RESP : LAUNCH) : IDLE;
      LAUNCH:  nxt = WAIT;
      WAIT:    nxt = core_done ? FIX : timeout ? RESP : WAIT;
      FIX:     nxt = RESP;
      RESP:    nxt = bus.resp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      fold <= 1'b0;
      yneg <= 1'b0;
      core_mode <= 1'b0;
      core_x <= '0;
      core_y <= '0;
      core_z <= '0;
      bus.resp_x <= '0;
      bus.resp_y <= '0;
      bus.resp_z <= '0;
      bus.resp_err <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (bus.req_valid) begin
          core_mode <= bus.req_mode;
          fold <= bus.req_mode ? bus.req_a[W-1] : rot_fold;
          yneg <= bus.req_b[W-1];
          cnt <= '0;
          core_x <= !bus.req_mode ? '0 : bus.req_a[W-1] ? neg(bus.req_a) : bus.req_a;
          core_y <= !bus.req_mode ? '0 : bus.req_a[W-1] ? neg(bus.req_b) : bus.req_b;
          core_z <= bus.req_mode ? '0 : bus.req_a > HPI ? add(bus.req_a, NPI) :
                    bus.req_a < NHPI ? add(bus.req_a, PI) : bus.req_a;
          {bus.resp_x, bus.resp_y, bus.resp_z} <= '0;
          bus.resp_err <= rot_err;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (core_done) begin
            bus.resp_x <= core_x_out;
            bus.resp_y <= core_y_out;
            bus.resp_z <= core_z_out;
          end else if (timeout) bus.resp_err <= 1'b1;
        end
        // a folded rotation lands a half-turn away, a folded vector lost pi from its angle
        FIX: begin
          if (fold && !core_mode) begin
            bus.resp_x <= neg(bus.resp_x);
            bus.resp_y <= neg(bus.resp_y);
          end
          if (fold && core_mode) bus.resp_z <= add(bus.resp_z, yneg ? NPI : PI);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_sequencer.sv
// tb_cordic_sequencer: random and directed jobs against a trig reference model, with a
// range-limited behavioural cordic core; a scoreboard monitor checks every response.
module tb_cordic_sequencer;
  localparam int W = 32;
  localparam int TIMEOUT = 64;
  localparam longint PI = 102944;
  localparam longint HPI = 51472;
  localparam int MINI = -2147483647 - 1;
  typedef struct {bit err; longint x, y, z, txy, tz;} exp_t;
  logic clk = 0;
  logic rst = 0;
  logic core_start, core_mode, core_done;
  logic signed [W-1:0] core_x, core_y, core_z, core_x_out, core_y_out, core_z_out;
  exp_t q[$];
  int checks = 0, fails = 0, starts = 0, late_req = 0, rmode = 0;
  bit mute = 0;
  longint lx, ly, lz;
  cordic_sequencer_if #(.W(W)) bus ();
  cordic_sequencer #(.W(W), .PI_FIXED(102944), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .core_start(core_start), .core_mode(core_mode),
    .core_x(core_x), .core_y(core_y), .core_z(core_z),
    .core_done(core_done),
    .core_x_out(core_x_out), .core_y_out(core_y_out), .core_z_out(core_z_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input longint act, input longint exp, input longint tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", n, act, exp, tol);
    end
  endtask
  // ideal result from the original operands: true trig, no folding involved
  function automatic exp_t model(input bit m, input longint a, input longint b);
    exp_t e = '{err: 0, x: 0, y: 0, z: 0, txy: 0, tz: 0};
    if (!m) begin
      if (a > PI || a < -PI) e.err = 1;
      else begin
        e.x = longint'(32768.0 * $cos(real'(a) / 32768.0));
        e.y = longint'(32768.0 * $sin(real'(a) / 32768.0));
        e.txy = 8;
        e.tz = 16;
      end
    end else begin
      e.x = longint'($sqrt(real'(a) * real'(a) + real'(b) * real'(b)));
      e.z = longint'(32768.0 * $atan2(real'(b), real'(a)));
      e.txy = 16;
      e.tz = 16;
    end
    return e;
  endfunction
  task automatic send(input bit m, input int a, input int b, input bit to);
    exp_t e = model(m, a, b);
    bit re = e.err;
    int n = 0;
    if (to) e = '{err: 1, x: 0, y: 0, z: 0, txy: 0, tz: 0};
    q.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1; bus.req_mode = m; bus.req_a = a; bus.req_b = b;
    @(negedge clk);
    while (!bus.req_ready && n < 300) begin @(negedge clk); n++; end
    chk("accept", bus.req_ready, 1, 0);
    @(posedge clk); #1;
    bus.req_valid = 0;
    @(negedge clk);
    if (re) begin
      chk("err_latency", bus.resp_valid, 1, 0);
      chk("err_no_start", core_start, 0, 0);
    end else chk("start_latency", core_start, 1, 0);
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.resp_valid) && n < 500) begin @(negedge clk); n++; end
    chk("drain", q.size(), 0, 0);
  endtask
  // consumer backpressure: 0 random, 1 held low, 2 held high
  initial begin
    bus.resp_ready = 0;
    forever begin
      @(posedge clk); #1;
      bus.resp_ready = rmode == 1 ? 1'b0 : rmode == 2 ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && bus.resp_valid && bus.resp_ready) begin
        if (q.size() == 0) chk("spurious_resp", 1, 0, 0);
        else begin
          e = q.pop_front();
          chk("resp_err", bus.resp_err, e.err, 0);
          chk("resp_x", bus.resp_x, e.x, e.txy);
          chk("resp_y", bus.resp_y, e.y, e.txy);
          chk("resp_z", bus.resp_z, e.z, e.tz);
        end
      end
    end
  end
  // cordic core stand-in: only converges inside |z|<=pi/2 and x>=0
  initial begin
    int late_seen = 0;
    real xc, yc, zc;
    longint nx, ny, nz;
    core_done = 0; core_x_out = 0; core_y_out = 0; core_z_out = 0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        starts++;
        lx = core_x; ly = core_y; lz = core_z;
        if (!core_mode) begin
          chk("core_z_range", longint'(core_z >= -HPI && core_z <= HPI), 1, 0);
          chk("core_xy_zero", longint'(core_x == 0 && core_y == 0), 1, 0);
          zc = core_z > HPI ? real'(HPI) : core_z < -HPI ? -real'(HPI) : real'(core_z);
          nx = longint'(32768.0 * $cos(zc / 32768.0));
          ny = longint'(32768.0 * $sin(zc / 32768.0));
          nz = 0;
        end else begin
          chk("core_x_nonneg", longint'(core_x >= 0), 1, 0);
          chk("core_z_zero", core_z, 0, 0);
          xc = core_x > 0 ? real'(core_x) : 0.0;
          yc = real'(core_y);
          nx = longint'($sqrt(xc * xc + yc * yc));
          ny = 0;
          nz = longint'(32768.0 * $atan2(yc, xc));
        end
        @(negedge clk);
        chk("start_pulse", core_start, 0, 0);
        if (!mute) begin
          repeat ($urandom_range(1, 6)) @(posedge clk);
          #1;
          core_done = 1; core_x_out = 32'(nx); core_y_out = 32'(ny); core_z_out = 32'(nz);
          @(posedge clk); #1;
          core_done = 0; core_x_out = $urandom; core_y_out = $urandom; core_z_out = $urandom;
          @(negedge clk);
          chk("resp_early", bus.resp_valid, 0, 0);
          @(negedge clk);
          chk("resp_latency", bus.resp_valid, 1, 0);
        end
      end else if (late_req != late_seen) begin
        late_seen = late_req;
        @(posedge clk); #1;
        core_done = 1; core_x_out = $urandom; core_y_out = $urandom; core_z_out = $urandom;
        @(posedge clk); #1;
        core_done = 0;
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    exp_t dummy;
    int s0, n, ra, rb;
    longint sx, sy, sz;
    bus.req_valid = 0; bus.req_mode = 0; bus.req_a = 0; bus.req_b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1, 0);
    chk("rst_resp_valid", bus.resp_valid, 0, 0);
    chk("rst_resp_err", bus.resp_err, 0, 0);
    chk("rst_core_start", core_start, 0, 0);
    chk("rst_core_mode", core_mode, 0, 0);
    chk("rst_core_xz", longint'(core_x == 0 && core_z == 0 && bus.resp_x == 0), 1, 0);
    @(posedge clk); #1;
    rst = 1;
    rmode = 2;
    send(0, 25736, 0, 0); drain(); chk("t1_core_z", lz, 25736, 0);
    send(0, 77208, 0, 0); drain(); chk("t2_core_z", lz, -25736, 0);
    send(1, -40960, 77005, 0); drain();
    chk("t3_core_x", lx, 40960, 0); chk("t3_core_y", ly, -77005, 0);
    s0 = starts;
    send(0, 110000, 0, 0); drain(); chk("t4_no_start", starts, s0, 0);
    send(0, 51472, 0, 0); drain(); chk("hpi_no_fold", lz, 51472, 0);
    send(0, -51472, 0, 0); drain(); chk("nhpi_no_fold", lz, -51472, 0);
    send(0, 102944, 0, 0); drain(); chk("pi_fold", lz, 0, 0);
    send(0, -102944, 0, 0); drain(); chk("npi_fold", lz, 0, 0);
    send(0, 102945, 0, 0); drain();
    send(1, 0, 0, 0); drain(); chk("zero_vec_x", lx, 0, 0);
    send(1, MINI, 0, 0); drain(); chk("sat_neg_x", lx, 2147483647, 0);
    send(1, -5, MINI, 0); drain(); chk("sat_neg_y", ly, 2147483647, 0);
    // backpressure: result must hold while the consumer stalls
    rmode = 1;
    send(0, 12345, 0, 0);
    n = 0;
    while (!bus.resp_valid && n < 100) begin @(negedge clk); n++; end
    chk("t5_valid", bus.resp_valid, 1, 0);
    sx = bus.resp_x; sy = bus.resp_y; sz = bus.resp_z;
    repeat (5) begin
      @(negedge clk);
      chk("t5_hold", longint'(bus.resp_x == sx && bus.resp_y == sy && bus.resp_z == sz), 1, 0);
      chk("t5_req_ready_low", bus.req_ready, 0, 0);
    end
    rmode = 2;
    n = 0;
    while (!(bus.resp_valid && bus.resp_ready) && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("t5_req_ready_after", bus.req_ready, 1, 0);
    // core never answers: timeout, then a stray done while idle
    rmode = 0;
    drain();
    mute = 1;
    send(1, 300, -200, 1);
    n = 0;
    while (!bus.resp_valid && n < 200) begin @(negedge clk); n++; end
    chk("timeout_latency", n, TIMEOUT + 1, 1);
    drain();
    mute = 0;
    late_req++;
    repeat (6) @(negedge clk);
    chk("late_done_ready", bus.req_ready, 1, 0);
    chk("late_done_no_resp", bus.resp_valid, 0, 0);
    // reset while waiting on the core abandons the job
    mute = 1;
    send(0, 1000, 0, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    if (q.size() != 0) dummy = q.pop_back();
    @(negedge clk);
    chk("wait_rst_ready", bus.req_ready, 1, 0);
    chk("wait_rst_core_z", core_z, 0, 0);
    mute = 0;
    repeat (3) @(negedge clk);
    chk("wait_rst_no_resp", bus.resp_valid, 0, 0);
    send(0, -30000, 0, 0);
    drain();
    repeat (60) begin
      if ($urandom_range(0, 1) == 0) begin
        ra = int'($urandom_range(0, 230000)) - 115000;
        rb = $urandom;
        send(0, ra, rb, 0);
      end else begin
        ra = int'($urandom_range(0, 2097152)) - 1048576;
        rb = int'($urandom_range(0, 2097152)) - 1048576;
        send(1, ra, rb, 0);
      end
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
